// File: rtl/aoc3_pkg.sv
// Shared types and helpers for the Day-3 joltage picker: FSM states, digit width
// and the shift-add multiply-by-ten used by the digit-serial converter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package aoc3_pkg;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    POP     = 2'd1,
    CONVERT = 2'd2,
    EMIT    = 2'd3
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int ACC_W   = `DATA_WIDTH;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  function automatic logic [ACC_W-1:0] mul10(input logic [ACC_W-1:0] a);
    return (a << 3'd3) + (a << 3'd1);
  endfunction

  // Smallest width able to hold a K-digit decimal value: ceil(K*3.33).
  function automatic int min_width(input int k);
    return (k * 333 + 99) / 100;
  endfunction

endpackage

// File: rtl/aoc3_digit_stack.sv
// Bounded LIFO of decimal digits with clear and a combinational indexed read port,
// plus a small checker that flags a push and a pop requested in the same cycle.
module aoc3_digit_stack_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_push,
  input logic i_pop,
  input logic i_clear
);
  a_no_push_pop: assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
                                  !(i_push && i_pop));
endmodule

module aoc3_digit_stack
  import aoc3_pkg::*;
#(
  parameter  int DEPTH  = 12,
  localparam int SIZE_W = $clog2(DEPTH) + 1,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [DIGIT_W-1:0] i_din,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [DIGIT_W-1:0] o_top,
  output logic [DIGIT_W-1:0] o_rd_data,
  output logic [SIZE_W-1:0]  o_size,
  output logic               o_full,
  output logic               o_empty
);

  logic [DIGIT_W-1:0] r_mem [DEPTH];
  logic [SIZE_W-1:0]  r_size;
  logic [IDX_W-1:0]   w_top_idx;

  assign o_size    = r_size;
  assign o_full    = (r_size == SIZE_W'(DEPTH));
  assign o_empty   = (r_size == {SIZE_W{1'b0}});
  assign w_top_idx = IDX_W'(r_size - SIZE_W'(1));
  assign o_rd_data = r_mem[i_rd_idx];

  // Top-of-stack view; reads as zero when empty so no stale digit leaks out.
  always_comb begin
    o_top = {DIGIT_W{1'b0}};
    if (!o_empty) begin
      o_top = r_mem[w_top_idx];
    end else begin
      o_top = {DIGIT_W{1'b0}};
    end
  end

  // Storage and occupancy; a push when full is dropped, never overwrites.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_size <= {SIZE_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DIGIT_W{1'b0}};
      end
    end else if (i_clear) begin
      r_size <= {SIZE_W{1'b0}};
    end else if (i_push && !o_full) begin
      r_mem[IDX_W'(r_size)] <= i_din;
      r_size                <= r_size + SIZE_W'(1);
    end else if (i_pop && !o_empty) begin
      r_size <= r_size - SIZE_W'(1);
    end
  end

  aoc3_digit_stack_chk u_chk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (i_push),
    .i_pop  (i_pop),
    .i_clear(i_clear)
  );

endmodule

// File: rtl/aoc3_joltage_picker.sv
// Streaming picker: keeps the lexicographically largest K-digit subsequence of each
// fixed-length line on a monotonic stack, converts it to binary and accumulates it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module aoc3_joltage_picker
  import aoc3_pkg::*;
#(
  parameter  int K          = 12,
  parameter  int LINE_LEN   = 15,
  parameter  int DATA_WIDTH = `DATA_WIDTH,
  localparam int SIZE_W     = $clog2(K) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            data_in,
  input  logic                  data_in_valid,
  input  logic                  newline,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] line_value,
  output logic                  line_valid,
  output logic [DATA_WIDTH-1:0] total,
  output logic [15:0]           line_count,
  output logic [SIZE_W-1:0]     size,
  output logic                  err
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int POS_W = $clog2(LINE_LEN + 1);
  localparam int CMP_W = $clog2(LINE_LEN + K + 2) + 1;

  if (DATA_WIDTH < min_width(K)) begin : g_bad_width
    $error("DATA_WIDTH too small to hold a K-digit value");
  end
  if (LINE_LEN < K) begin : g_bad_len
    $error("LINE_LEN must be at least K");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [POS_W-1:0]      r_idx;
  logic [DIGIT_W-1:0]    r_pend;
  logic                  r_pend_last;
  logic [IDX_W-1:0]      r_cidx;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_line_value;
  logic [DATA_WIDTH-1:0] r_total;
  logic [15:0]           r_line_count;
  logic                  r_line_valid;
  logic                  r_err;

  logic [DIGIT_W-1:0]    w_top;
  logic [DIGIT_W-1:0]    w_rd_data;
  logic [SIZE_W-1:0]     w_size;
  logic                  w_full;
  logic                  w_empty;
  logic [DIGIT_W-1:0]    w_cand;
  logic                  w_pop_ok;
  logic                  w_last_pos;
  logic [DATA_WIDTH-1:0] w_acc_x10;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  logic w_push, w_pop, w_clear, w_idx_inc, w_idx_clr, w_err_set;
  logic w_latch_pend, w_conv_start, w_conv_step, w_emit;

  if (DATA_WIDTH <= ACC_W) begin : g_mul_pkg
    assign w_acc_x10 = DATA_WIDTH'(mul10(ACC_W'(r_acc)));
  end else begin : g_mul_wide
    assign w_acc_x10 = (r_acc << 3'd3) + (r_acc << 3'd1);
  end
  assign w_acc_nxt  = w_acc_x10 + DATA_WIDTH'(w_rd_data);
  assign w_last_pos = (r_idx == POS_W'(LINE_LEN - 1));

  // Pop guard: a smaller top may go only if enough digits remain to refill K slots.
  always_comb begin
    w_cand = data_in;
    if (r_state == POP) begin
      w_cand = r_pend;
    end else begin
      w_cand = data_in;
    end
    w_pop_ok = !w_empty && (w_top < w_cand) &&
               ((CMP_W'(w_size) + CMP_W'(LINE_LEN)) > (CMP_W'(r_idx) + CMP_W'(K)));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_clear      = 1'b0;
    w_idx_inc    = 1'b0;
    w_idx_clr    = 1'b0;
    w_err_set    = 1'b0;
    w_latch_pend = 1'b0;
    w_conv_start = 1'b0;
    w_conv_step  = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      ACCEPT: begin
        if (data_in_valid) begin
          if (data_in > DIGIT_MAX) begin
            w_err_set = 1'b1;
          end else if (newline != w_last_pos) begin
            // Short line or missing newline: discard the partial line.
            w_err_set = 1'b1;
            w_clear   = 1'b1;
            w_idx_clr = 1'b1;
          end else if (w_pop_ok) begin
            w_pop        = 1'b1;
            w_latch_pend = 1'b1;
            w_state_nxt  = POP;
          end else begin
            w_push    = !w_full;
            w_idx_inc = 1'b1;
            if (newline) begin
              w_conv_start = 1'b1;
              w_state_nxt  = CONVERT;
            end else begin
              w_state_nxt = ACCEPT;
            end
          end
        end else begin
          w_state_nxt = ACCEPT;
        end
      end
      POP: begin
        if (w_pop_ok) begin
          w_pop = 1'b1;
        end else begin
          w_push    = !w_full;
          w_idx_inc = 1'b1;
          if (r_pend_last) begin
            w_conv_start = 1'b1;
            w_state_nxt  = CONVERT;
          end else begin
            w_state_nxt = ACCEPT;
          end
        end
      end
      CONVERT: begin
        w_conv_step = 1'b1;
        if (r_cidx == IDX_W'(K - 1)) begin
          w_state_nxt = EMIT;
        end else begin
          w_state_nxt = CONVERT;
        end
      end
      EMIT: begin
        w_emit      = 1'b1;
        w_clear     = 1'b1;
        w_idx_clr   = 1'b1;
        w_state_nxt = ACCEPT;
      end
      default: begin
        w_state_nxt = ACCEPT;
      end
    endcase
  end

  // Line position, pending digit, converter and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx        <= {POS_W{1'b0}};
      r_pend       <= {DIGIT_W{1'b0}};
      r_pend_last  <= 1'b0;
      r_cidx       <= {IDX_W{1'b0}};
      r_acc        <= {DATA_WIDTH{1'b0}};
      r_line_value <= {DATA_WIDTH{1'b0}};
      r_total      <= {DATA_WIDTH{1'b0}};
      r_line_count <= 16'd0;
      r_line_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_idx_clr) begin
        r_idx <= {POS_W{1'b0}};
      end else if (w_idx_inc) begin
        r_idx <= r_idx + POS_W'(1);
      end
      if (w_latch_pend) begin
        r_pend      <= data_in;
        r_pend_last <= newline;
      end
      if (w_conv_start) begin
        r_cidx <= {IDX_W{1'b0}};
        r_acc  <= {DATA_WIDTH{1'b0}};
      end else if (w_conv_step) begin
        r_cidx <= r_cidx + IDX_W'(1);
        r_acc  <= w_acc_nxt;
      end
      r_line_valid <= w_emit;
      if (w_emit) begin
        r_line_value <= r_acc;
        r_total      <= r_total + r_acc;
        r_line_count <= r_line_count + 16'd1;
      end
    end
  end

  aoc3_digit_stack #(.DEPTH(K)) u_stack (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clear  (w_clear),
    .i_din    (w_cand),
    .i_rd_idx (r_cidx),
    .o_top    (w_top),
    .o_rd_data(w_rd_data),
    .o_size   (w_size),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign data_in_ready = (r_state == ACCEPT);
  assign line_value    = r_line_value;
  assign line_valid    = r_line_valid;
  assign total         = r_total;
  assign line_count    = r_line_count;
  assign size          = w_size;
  assign err           = r_err;

endmodule

// File: tb/tb_aoc3_joltage_picker.sv
// Bench for aoc3_joltage_picker: a K=2 and a K=12 instance checked against a greedy
// max-subsequence model, with directed framing, digit-error and reset cases.
module tb_aoc3_joltage_picker;

  typedef int dq_t[$];

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst  [2];
  logic [3:0]  din  [2];
  logic        vld  [2];
  logic        nl   [2];
  logic        rdy  [2];
  logic [63:0] lval [2];
  logic        lvv  [2];
  logic [63:0] tot  [2];
  logic [15:0] lcnt [2];
  logic        er   [2];
  logic [1:0]  sz0;
  logic [4:0]  sz1;

  int n_chk  = 0;
  int n_fail = 0;
  int stall [2];
  longint unsigned m_total [2];
  int              m_count [2];
  longint unsigned exp0[$];
  longint unsigned exp1[$];

  string lines [4] = '{"987654321111111", "811111111111119",
                       "234234234234278", "818181911112111"};

  aoc3_joltage_picker #(.K(2), .LINE_LEN(15), .DATA_WIDTH(64)) dut2 (
    .clock(clock), .reset(rst[0]), .data_in(din[0]), .data_in_valid(vld[0]),
    .newline(nl[0]), .data_in_ready(rdy[0]), .line_value(lval[0]),
    .line_valid(lvv[0]), .total(tot[0]), .line_count(lcnt[0]), .size(sz0),
    .err(er[0]));

  aoc3_joltage_picker #(.K(12), .LINE_LEN(15), .DATA_WIDTH(64)) dut12 (
    .clock(clock), .reset(rst[1]), .data_in(din[1]), .data_in_valid(vld[1]),
    .newline(nl[1]), .data_in_ready(rdy[1]), .line_value(lval[1]),
    .line_valid(lvv[1]), .total(tot[1]), .line_count(lcnt[1]), .size(sz1),
    .err(er[1]));

  function automatic void chk(string name, longint unsigned act, longint unsigned expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  function automatic int kof(int u);
    return (u == 0) ? 2 : 12;
  endfunction

  function automatic dq_t parse(string s);
    dq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(int'(s[i]) - 48);
    return q;
  endfunction

  // Greedy: for each output slot take the earliest maximum digit that still
  // leaves enough digits to the right to fill the remaining slots.
  function automatic longint unsigned pick(dq_t ds, int k);
    longint unsigned v = 0;
    int start = 0;
    int n = ds.size();
    for (int j = 0; j < k; j++) begin
      int best = -1;
      int bi = start;
      for (int i = start; i <= n - k + j; i++) begin
        if (ds[i] > best) begin
          best = ds[i];
          bi = i;
        end
      end
      v = v * 10 + longint'(best);
      start = bi + 1;
    end
    return v;
  endfunction

  function automatic void push_exp(int u, longint unsigned v);
    if (u == 0) exp0.push_back(v); else exp1.push_back(v);
  endfunction

  function automatic int exp_size(int u);
    return (u == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic longint unsigned pop_exp(int u);
    if (u == 0) return exp0.pop_front();
    else return exp1.pop_front();
  endfunction

  // Compare process: result pulses against the model queue, totals every cycle.
  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst[u]) begin
        if (lvv[u]) begin
          if (exp_size(u) == 0) begin
            chk($sformatf("unexpected_line_valid_u%0d", u), 64'd1, 64'd0);
          end else begin
            longint unsigned e;
            e = pop_exp(u);
            m_total[u] += e;
            m_count[u]++;
            chk($sformatf("line_value_u%0d", u), lval[u], e);
          end
        end
        chk($sformatf("total_u%0d", u), tot[u], m_total[u]);
        chk($sformatf("line_count_u%0d", u), lcnt[u], longint'(m_count[u]));
      end
    end
    chk("size_bound_k2", longint'(sz0 <= 2'd2), 64'd1);
    chk("size_bound_k12", longint'(sz1 <= 5'd12), 64'd1);
  end

  task automatic beat(int u, int d, bit last);
    int c = 0;
    din[u] = 4'(d);
    nl[u]  = last;
    vld[u] = 1'b1;
    while (!rdy[u] && c < 100) begin
      @(negedge clock);
      c++;
    end
    if (c >= 100) chk("ready_timeout", 64'd1, 64'd0);
    stall[u] += c;
    @(negedge clock);
  endtask

  task automatic send_digits(int u, dq_t ds, int nl_at, bit expect_out);
    dq_t good;
    if (expect_out) begin
      foreach (ds[i]) if (ds[i] <= 9) good.push_back(ds[i]);
      push_exp(u, pick(good, kof(u)));
    end
    for (int i = 0; i < ds.size(); i++) beat(u, ds[i], i == nl_at);
    vld[u] = 1'b0;
    nl[u]  = 1'b0;
  endtask

  task automatic drain(int u);
    int c = 0;
    while ((exp_size(u) != 0 || !rdy[u]) && c < 200) begin
      @(negedge clock);
      c++;
    end
    if (c >= 200) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic rst_unit(int u);
    rst[u] = 1'b1;
    vld[u] = 1'b0;
    if (u == 0) exp0.delete(); else exp1.delete();
    m_total[u] = 0;
    m_count[u] = 0;
    @(negedge clock);
    rst[u] = 1'b0;
  endtask

  initial begin
    dq_t ds;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; vld[u] = 1'b0; nl[u] = 1'b0; din[u] = 4'd0;
      stall[u] = 0; m_total[u] = 0; m_count[u] = 0;
    end
    repeat (2) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      chk("reset_line_value", lval[u], 64'd0);
      chk("reset_line_valid", longint'(lvv[u]), 64'd0);
      chk("reset_total", tot[u], 64'd0);
      chk("reset_line_count", longint'(lcnt[u]), 64'd0);
      chk("reset_err", longint'(er[u]), 64'd0);
    end
    chk("reset_size_k2", longint'(sz0), 64'd0);
    chk("reset_size_k12", longint'(sz1), 64'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Pin the model with hand-computed values.
    chk("model_k2_a", pick(parse(lines[0]), 2), 64'd98);
    chk("model_k2_b", pick(parse(lines[1]), 2), 64'd89);
    chk("model_k2_c", pick(parse(lines[2]), 2), 64'd78);
    chk("model_k2_d", pick(parse(lines[3]), 2), 64'd92);
    chk("model_k12_c", pick(parse(lines[2]), 12), 64'd434234234278);
    chk("model_k12_d", pick(parse(lines[3]), 12), 64'd888911112111);

    // Part 1 and part 2 on the four sample lines, back to back.
    for (int i = 0; i < 4; i++) send_digits(0, parse(lines[i]), 14, 1'b1);
    drain(0);
    chk("k2_total_literal", tot[0], 64'd357);
    chk("k2_count_literal", longint'(lcnt[0]), 64'd4);
    for (int i = 0; i < 4; i++) send_digits(1, parse(lines[i]), 14, 1'b1);
    drain(1);
    chk("k12_total_literal", tot[1], 64'd3121910778619);
    chk("k12_count_literal", longint'(lcnt[1]), 64'd4);

    // Valid held high: one stall per pop-triggering digit inside the line.
    stall[0] = 0;
    send_digits(0, parse("123456789123456"), 14, 1'b1);
    chk("popline_stalls", longint'(stall[0]), 64'd12);
    drain(0);
    chk("popline_value_literal", lval[0], 64'd96);
    chk("popline_count_literal", longint'(lcnt[0]), 64'd5);

    // Framing: newline on the 10th digit.
    rst_unit(0);
    chk("pre_framing_err", longint'(er[0]), 64'd0);
    send_digits(0, parse("1234567891"), 9, 1'b0);
    repeat (6) @(negedge clock);
    chk("framing_err", longint'(er[0]), 64'd1);
    chk("framing_size_cleared", longint'(sz0), 64'd0);
    chk("framing_no_line", longint'(lcnt[0]), 64'd0);
    send_digits(0, parse("987654321111111"), 14, 1'b1);
    drain(0);
    chk("framing_recover_value", lval[0], 64'd98);

    // Reset while the second line is converting.
    rst_unit(0);
    send_digits(0, parse("987654321111111"), 14, 1'b1);
    drain(0);
    send_digits(0, parse("234234234234278"), 14, 1'b0);
    rst_unit(0);
    repeat (8) @(negedge clock);
    chk("abort_total", tot[0], 64'd0);
    chk("abort_count", longint'(lcnt[0]), 64'd0);
    chk("abort_size", longint'(sz0), 64'd0);
    send_digits(0, parse("811111111111119"), 14, 1'b1);
    drain(0);
    chk("abort_next_value", lval[0], 64'd89);
    chk("abort_next_total", tot[0], 64'd89);

    // Out-of-range digit mid-line is dropped without advancing the line.
    rst_unit(0);
    ds = parse("987654321111111");
    ds.insert(3, 10);
    push_exp(0, 64'd98);
    for (int i = 0; i < ds.size(); i++) begin
      beat(0, ds[i], i == 15);
      if (i == 2) chk("digit_err_before", longint'(er[0]), 64'd0);
      if (i == 3) begin
        chk("digit_err_set", longint'(er[0]), 64'd1);
        chk("digit_err_size", longint'(sz0), 64'd2);
      end
    end
    vld[0] = 1'b0;
    nl[0]  = 1'b0;
    drain(0);
    chk("digit_err_value", lval[0], 64'd98);
    chk("digit_err_count", longint'(lcnt[0]), 64'd1);

    repeat (4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aoc3_joltage_picker.md
Name: aoc3_joltage_picker

Overview:
- Streaming Day-3 solver. Consumes one decimal digit per handshake for lines of exactly LINE_LEN digits.
- Selects the lexicographically largest K-digit subsequence of each line using a bounded monotonic stack, then converts it to binary.
- Emits the per-line value and keeps a running total.
- Successor to the fixed-capacity stack top: K, LINE_LEN and width are parametrised, and it adds backpressure, line framing checks, digit-serial conversion and accumulation.

Parameters:
- K, 12: number of digits picked per line (2 for part 1, 12 for part 2).
- LINE_LEN, 15: digits per line; must satisfy LINE_LEN >= K.
- DATA_WIDTH, `DATA_WIDTH: width of the value and total; elaboration error if < ceil(K*3.33).

Ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- data_in, in, 4: digit 0..9.
- data_in_valid, in, 1: data_in is valid.
- newline, in, 1: qualifies the current beat as the last digit of the line.
- data_in_ready, out, 1: block accepts a beat this cycle.
- line_value, out, DATA_WIDTH: K-digit result of the last completed line.
- line_valid, out, 1: one-cycle pulse when line_value updates.
- total, out, DATA_WIDTH: sum of all line_value since reset; wraps mod 2^DATA_WIDTH.
- line_count, out, 16: completed lines.
- size, out, $clog2(K)+1: current stack occupancy (debug).
- err, out, 1: sticky framing or digit error.

Behaviour:
- Reset: one clock and synchronous active-high reset, named clock and reset. On reset, all outputs are 0, the stack is empty, idx=0 and the state is ACCEPT. Reset asserted mid-line or mid-conversion aborts the operation on the next edge; no line_valid is produced.
- Handshake: a beat transfers when data_in_valid && data_in_ready. data_in_ready=1 only in ACCEPT.
- Definitions: r = LINE_LEN - idx, the number of digits remaining including the current one. pop_ok = size>0 && top<d && (size-1+r) >= K.
- ACCEPT, on transfer of d:
  - If pop_ok: pop this cycle, latch d into pend, go to POP.
  - Otherwise: push d if size<K, else drop d. Increment idx.
  - Sustains 1 digit/cycle when no pop is needed.
- POP: evaluate pop_ok with pend each cycle; pop at most one entry per cycle. When pop_ok is false, push or drop pend and increment idx. Then go to CONVERT if pend was the last digit, else go to ACCEPT.
- Last digit: the beat with newline=1. If newline=1 arrives with idx != LINE_LEN-1, or idx reaches LINE_LEN without newline:
  - set err;
  - clear the stack and idx;
  - no line_valid is produced;
  - return to ACCEPT.
- A digit > 9 sets err. The beat is consumed and ignored, and idx is not advanced.
- Invariant: at the end of a valid line, size == K. This is guaranteed by the pop guard.
- CONVERT: K cycles, reading stack entries bottom (index 0) to top, with acc = acc*10 + entry.
  - The multiply is done as (acc<<3)+(acc<<1), truncated to DATA_WIDTH.
  - The next cycle pulses line_valid with line_value=acc, updates total += acc and increments line_count.
  - Stack and idx are cleared and the state returns to ACCEPT.
- Latency: line_valid asserts K+1 cycles after the last-digit transfer when no pops are pending. Pops add one cycle each.
- Stack: never holds more than K entries. A push when full is a drop, never an overwrite.
- line_value and total hold their values between pulses.

Decomposition:
- Package aoc3_pkg:
  - state enum {ACCEPT, POP, CONVERT, EMIT};
  - DIGIT_W=4;
  - function mul10(logic [DATA_WIDTH-1:0]).
- Sub-module aoc3_digit_stack #(DEPTH=K):
  - K-deep LIFO with push, pop and clear;
  - outputs top, size, full, empty;
  - combinational indexed read port rd_idx/rd_data for CONVERT;
  - simultaneous push and pop is illegal, with an assertion.

Test Plan:
- K=2, LINE_LEN=15, lines 987654321111111, 811111111111119, 234234234234278, 818181911112111 -> line_value 98, 89, 78, 92; total=357; line_count=4.
- K=12, same four lines -> 987654321111, 811111111119, 434234234278, 888911112111; total=3121910778619.
- K=2, line 123456789123456 with data_in_valid held high -> data_in_ready drops for exactly one cycle after each pop-triggering digit; line_value=96; no beat lost or duplicated.
- Framing: newline on the 10th digit -> err=1, no line_valid; the next well-formed line 987654321111111 still yields 98.
- Reset asserted during CONVERT of line 2 -> line_valid never pulses for it; total, line_count and size are 0; the following line 811111111111119 yields 89 with total=89.
- Digit 0xA mid-line -> err=1, idx unchanged; the line completes normally after the remaining valid digits.
